// File: rtl/uart_word_pkg.sv
// Shared definitions for the UART word receiver: byte FSM state encoding
// and the bit-period computation.
package uart_word_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // Clocks per serial bit; integer division truncates toward zero.
  function automatic int unsigned bit_max(input int unsigned clk_freq,
                                          input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit sampling, byte FSM.
// Emits one-cycle byte_valid / frame_err pulses in the mid-stop sample cycle.
module uart_byte_rx
  import uart_word_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
`ifdef UART_WORD_TIMEOUT_EN
  ,
  output logic       idle
`endif
);

  localparam int unsigned BIT_MAX = bit_max(CLK_FREQ, BAUD);
  localparam int unsigned HALF    = BIT_MAX / 2;
  localparam int          CNT_W   = $clog2(BIT_MAX + 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_MAX - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  rx_state_e        state, next_state;
  logic             sync_meta, line, line_d;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             bit_tick;

  // START waits half a bit; later states wait a full bit from the previous sample.
  assign bit_tick = (state == ST_START) ? (bit_cnt == HALF_LAST) : (bit_cnt == FULL_LAST);
  assign rx_byte  = shift;
`ifdef UART_WORD_TIMEOUT_EN
  assign idle     = (state == ST_IDLE);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b1;
      line      <= 1'b1;
      line_d    <= 1'b1;
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'd0;
    end else begin
      sync_meta <= uart_rx;
      line      <= sync_meta;
      line_d    <= line;
      state     <= next_state;
      if (state == ST_IDLE || bit_tick) bit_cnt <= '0;
      else                              bit_cnt <= bit_cnt + 1'b1;
      if (state != ST_DATA)             bit_idx <= 3'd0;
      else if (bit_tick)                bit_idx <= bit_idx + 3'd1;
      if (state == ST_DATA && bit_tick) shift <= {line, shift[7:1]};
    end
  end

  always_comb begin
    next_state = state;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (state)
      ST_IDLE:  if (line_d && !line) next_state = ST_START;
      ST_START: if (bit_tick) next_state = line ? ST_IDLE : ST_DATA;
      ST_DATA:  if (bit_tick && bit_idx == 3'd7) next_state = ST_STOP;
      ST_STOP: begin
        // Leaving at mid-stop lets a following start edge be seen without a gap.
        if (bit_tick) begin
          next_state = ST_IDLE;
          if (line) byte_valid = 1'b1;
          else      frame_err  = 1'b1;
        end
      end
      default:  next_state = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_word_rx.sv
// Packs four received bytes MSB-first into a 32-bit word.
// Define UART_WORD_TIMEOUT_EN to drop partial words after TIMEOUT_BITS idle bit times.
module uart_word_rx
  import uart_word_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        uart_rx,
  output logic        rx_done_computer,
  output logic [31:0] rx_data_computer,
  output logic        frame_err
);

  logic [7:0]  rx_byte;
  logic        byte_valid, byte_ferr, timeout;
  logic [1:0]  byte_idx;
  logic [31:0] word, next_word;

  assign next_word = {word[23:0], rx_byte};

`ifdef UART_WORD_TIMEOUT_EN
  localparam int unsigned BIT_MAX = bit_max(CLK_FREQ, BAUD);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_BITS * BIT_MAX - 1);
  logic        idle;
  logic [31:0] to_cnt;

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_byte_rx (
    .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx), .rx_byte(rx_byte),
    .byte_valid(byte_valid), .frame_err(byte_ferr), .idle(idle)
  );

  // Counts idle clocks only while a partial word is pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          to_cnt <= 32'd0;
    else if (!idle || byte_idx == 2'd0)    to_cnt <= 32'd0;
    else if (to_cnt != TIMEOUT_LAST)       to_cnt <= to_cnt + 32'd1;
  end
  assign timeout = idle && (byte_idx != 2'd0) && (to_cnt == TIMEOUT_LAST);
`else
  uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_byte_rx (
    .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx), .rx_byte(rx_byte),
    .byte_valid(byte_valid), .frame_err(byte_ferr)
  );
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_idx         <= 2'd0;
      word             <= 32'd0;
      rx_data_computer <= 32'd0;
      rx_done_computer <= 1'b0;
      frame_err        <= 1'b0;
    end else begin
      rx_done_computer <= 1'b0;
      frame_err        <= byte_ferr;
      if (byte_ferr || timeout) begin
        byte_idx <= 2'd0;
        word     <= 32'd0;
      end else if (byte_valid) begin
        word     <= next_word;
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) begin
          rx_data_computer <= next_word;
          rx_done_computer <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx: serial driver, word/frame-error model with
// expected queue, per-cycle compare process and final report.
module tb_uart_word_rx;

  localparam int unsigned CLK_FREQ     = 50_000_000;
  localparam int unsigned BAUD         = 2_400_000;
  localparam int unsigned TIMEOUT_BITS = 20;
  localparam int BIT  = CLK_FREQ / BAUD;
  localparam int HALF = BIT / 2;
`ifdef UART_WORD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        rx_done_computer;
  logic [31:0] rx_data_computer;
  logic        frame_err;

  uart_word_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TIMEOUT_BITS(TIMEOUT_BITS)) dut (
    .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx),
    .rx_done_computer(rx_done_computer), .rx_data_computer(rx_data_computer),
    .frame_err(frame_err)
  );

  // ---------------- clock ----------------
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  int          ferr_pending = 0;
  logic [31:0] cur_word = 32'd0;
  int          m_cnt = 0;
  logic [31:0] m_word = 32'd0;
  int          done_cnt = 0;
  int          ferr_cnt = 0;
  logic [31:0] last_done_word = 32'd0;
  int          last_done_cyc = 0;
  int          byte_start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  task automatic model_clear();
    m_cnt  = 0;
    m_word = 32'd0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) begin
      ferr_pending++;
      model_clear();
    end else begin
      m_word = (m_word << 8) | {24'd0, b};
      m_cnt++;
      if (m_cnt == 4) begin
        exp_q.push_back(m_word);
        model_clear();
      end
    end
  endtask

  // ---------------- compare process ----------------
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n) begin
        check("done_ferr_exclusive", {31'd0, rx_done_computer & frame_err}, 32'd0);
        if (rx_done_computer) begin
          done_cnt++;
          last_done_word = rx_data_computer;
          last_done_cyc  = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual=%h required=no_pulse", rx_data_computer);
          end else begin
            e = exp_q.pop_front();
            check("word", rx_data_computer, e);
            cur_word = e;
          end
        end else begin
          check("data_hold", rx_data_computer, cur_word);
        end
        if (frame_err) begin
          ferr_cnt++;
          checks++;
          if (ferr_pending == 0) begin
            failures++;
            $display("FAIL unexpected_frame_err actual=1 required=0");
          end else begin
            ferr_pending--;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic hold_bits(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    if (TO_EN && n > int'(TIMEOUT_BITS)) model_clear();
    hold_bits(1'b1, n * BIT);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
    model_byte(b, stop_ok);
    byte_start_cyc = cyc;
    hold_bits(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold_bits(b[i], BIT);
    hold_bits(stop_ok, BIT);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    uart_rx = 1'b1;
    cur_word = 32'd0;
    exp_q.delete();
    ferr_pending = 0;
    model_clear();
    repeat (3) @(negedge clk);
    check("reset_data", rx_data_computer, 32'd0);
    check("reset_done", {31'd0, rx_done_computer}, 32'd0);
    check("reset_ferr", {31'd0, frame_err}, 32'd0);
    reset_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);
  endtask

  task automatic end_scenario(input string name, input int exp_done, input int exp_ferr,
                              input logic [31:0] exp_last);
    repeat (4) @(negedge clk);
    check({name, "_pending_words"}, 32'(exp_q.size()), 32'd0);
    check({name, "_pending_ferr"}, 32'(ferr_pending), 32'd0);
    check({name, "_done_count"}, 32'(done_cnt), 32'(exp_done));
    check({name, "_ferr_count"}, 32'(ferr_cnt), 32'(exp_ferr));
    if (exp_done > 0) check({name, "_last_word"}, last_done_word, exp_last);
    done_cnt = 0;
    ferr_cnt = 0;
    idle_bits(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    @(negedge clk);
    do_reset();

    // Four bytes into one word; also pins pulse latency after the last start edge.
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hA0);
    lat = last_done_cyc - byte_start_cyc;
    checks++;
    if (lat < 9 * BIT + HALF || lat > 9 * BIT + HALF + 4) begin
      failures++;
      $display("FAIL done_latency actual=%0d required=%0d..%0d", lat, 9 * BIT + HALF, 9 * BIT + HALF + 4);
    end
    end_scenario("basic", 1, 0, 32'hFFFFFFA0);

    // 100 ns glitch on the idle line must not start a byte.
    hold_bits(1'b0, 5);
    idle_bits(2);
    send_byte(8'hDD); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    end_scenario("glitch", 1, 0, 32'hDD123456);

    // Bad stop bit drops the partial word.
    send_byte(8'hFF);
    send_byte(8'h01, 1'b0);
    idle_bits(1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    end_scenario("frame_err", 1, 1, 32'h11223344);

    // Long idle between bytes of a word.
    send_byte(8'hAA); send_byte(8'hBB);
    idle_bits(30);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    end_scenario("timeout", 1, 0, TO_EN ? 32'h01020304 : 32'hAABB0102);

    do_reset();

    // Back-to-back bytes, no idle gap.
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    end_scenario("b2b", 2, 0, 32'h04050607);

    // Reset during bit 3 of byte 2, then a clean word.
    send_byte(8'h11); send_byte(8'h22);
    hold_bits(1'b0, BIT);
    hold_bits(1'b1, BIT); hold_bits(1'b1, BIT); hold_bits(1'b0, BIT);
    hold_bits(1'b0, HALF);
    do_reset();
    send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
    end_scenario("reset_mid", 1, 0, 32'hCAFEBABE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_word_rx.md
UART_WORD_RX -- requirements
Module: uart_word_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate.
REQ-003 SHALL have parameter TIMEOUT_BITS, default 20, idle bit periods before a partial word is dropped.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port uart_rx  input  1  asynchronous serial line from the host PC, idle high.
REQ-007 SHALL have port rx_done_computer  output  1  one-cycle pulse: new 32-bit word valid.
REQ-008 SHALL have port rx_data_computer  output  32  last complete word, first received byte in [31:24].
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.

Function
REQ-010 SHALL pass uart_rx through a 2-flop synchronizer before any use.
REQ-011 SHALL use bit period BIT_MAX = CLK_FREQ/BAUD clocks (integer division) and sample at BIT_MAX/2 within each bit.
REQ-012 SHALL implement byte FSM states IDLE, START, DATA, STOP.
REQ-013 IDLE -> START on a high-to-low transition of the synchronized line.
REQ-014 START: at mid-bit, line low -> DATA; line high -> IDLE (glitch rejected, no output).
REQ-015 DATA: 8 bits sampled at mid-bit, LSB first; after bit 7 -> STOP.
REQ-016 STOP: at mid-bit, line high -> byte accepted; line low -> frame_err pulse, byte dropped, partial word cleared; both -> IDLE on the next clock.
REQ-017 Returning to IDLE at mid-stop SHALL allow back-to-back frames with no idle gap.
REQ-018 SHALL pack accepted bytes MSB-first: word <= {word[23:0], byte}; 2-bit byte index counts 0..3 and wraps to 0.
REQ-019 On the 4th accepted byte, rx_data_computer SHALL load the full word and rx_done_computer SHALL pulse high for exactly 1 clock, 1 clock after the mid-stop sample.
REQ-020 rx_data_computer SHALL hold its value until the next complete word; it SHALL NOT change on partial words.
REQ-021 frame_err and rx_done_computer SHALL never assert in the same cycle.

Reset
REQ-022 On reset_n low: FSM = IDLE, byte index = 0, word = 0, bit and timeout counters = 0, synchronizer flops = 1, rx_data_computer = 0, rx_done_computer = 0, frame_err = 0.
REQ-023 Reset mid-frame SHALL abandon the byte and partial word; the first complete frame after release SHALL be received as byte 0.

Configuration
REQ-024 Macro UART_WORD_TIMEOUT_EN defined: when byte index != 0 and the FSM stays in IDLE for TIMEOUT_BITS*BIT_MAX clocks after the last stop sample, the byte index SHALL clear and the partial word is dropped with no output pulse.
REQ-025 Macro UART_WORD_TIMEOUT_EN undefined: no timeout counter SHALL be built; a partial word SHALL persist indefinitely until completed, frame error or reset.

Structure
REQ-026 Package uart_word_pkg SHALL hold FSM state encoding constants and the BIT_MAX computation function.
REQ-027 Sub-module uart_byte_rx SHALL contain synchronizer, bit timing and byte FSM, and output a byte plus valid/frame_err pulses; the top level SHALL hold word packing and the timeout.

Verification
REQ-028 50 MHz/115200: bytes FF FF FF A0 -> one rx_done_computer pulse, rx_data_computer = 32'hFFFFFFA0, no frame_err.
REQ-029 100 ns low glitch on idle line, then bytes DD 12 34 56 -> no byte from the glitch, a single word 32'hDD123456.
REQ-030 Bytes FF, then 0x01 with stop bit low, then 11 22 33 44 -> one frame_err pulse, then word 32'h11223344.
REQ-031 With UART_WORD_TIMEOUT_EN: bytes AA BB, 30 idle bit times, then 01 02 03 04 -> word 32'h01020304; without the macro -> word 32'hAABB0102.
REQ-032 8 back-to-back bytes 00..07 -> two pulses, words 32'h00010203 then 32'h04050607.
REQ-033 reset_n pulsed low during bit 3 of byte 2 of a word -> all outputs 0; next bytes CA FE BA BE -> 32'hCAFEBABE.
